// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS unified-memory arbiter: default bus widths
// and the arbiter state encoding.
package mips_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE_IF = 3'd1,
        ST_SERVE_DM = 3'd2,
        ST_RESP_IF  = 3'd3,
        ST_RESP_DM  = 3'd4
    } state_e;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Bundle of the fetch, data and memory handshakes around the arbiter.
// slave = arbiter view, master = pipeline/memory view.
interface mips_mem_arbiter_if #(
    parameter int ADDR_W = mips_mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = mips_mem_pkg::DEF_DATA_W
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ready;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        output if_ready, if_rdata, if_stall, dm_ready, dm_rdata, dm_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        input  if_ready, if_rdata, if_stall, dm_ready, dm_rdata, dm_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mips_mem_timeout.sv
// Clearable saturating cycle counter; o_expired flags the cycle in which the
// LIMIT-th consecutive increment is requested.
module mips_mem_timeout #(
    parameter int LIMIT = 255,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_inc && (r_cnt == CNT_LAST);
endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates the unified memory port between IF and MEM stages with
// IF starvation guard and a sticky timeout error.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    mips_mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [SW-1:0]     r_starve_cnt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_if_ready;
    logic              r_dm_ready;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_err;

    logic w_serving;
    logic w_grant_if;
    logic w_grant_dm;
    logic w_done;
    logic w_abort;
    logic w_tmo_clr;
    logic w_tmo_inc;
    logic w_tmo_expired;

    assign w_serving = (r_state == ST_SERVE_IF) || (r_state == ST_SERVE_DM);
    assign w_tmo_clr = !w_serving;
    assign w_tmo_inc = w_serving && !bus.mem_ack;

    mips_mem_timeout #(
        .LIMIT (TIMEOUT),
        .CNT_W (8)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_tmo_clr),
        .i_inc     (w_tmo_inc),
        .o_expired (w_tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_dm  = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // DM wins a tie until IF has been passed over STARVE_LIMIT times
                if (bus.dm_req && (!bus.if_req || (r_starve_cnt < STARVE_MAX))) begin
                    w_grant_dm  = 1'b1;
                    w_state_nxt = ST_SERVE_DM;
                end else if (bus.if_req) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = ST_SERVE_IF;
                end
            end
            ST_SERVE_IF: begin
                if (bus.mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_RESP_IF;
                end else if (w_tmo_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_RESP_IF;
                end
            end
            ST_SERVE_DM: begin
                if (bus.mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_RESP_DM;
                end else if (w_tmo_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_RESP_DM;
                end
            end
            ST_RESP_IF:  w_state_nxt = ST_IDLE;
            ST_RESP_DM:  w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant_if) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= bus.if_addr;
            r_mem_wdata <= '0;
        end else if (w_grant_dm) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.dm_we;
            r_mem_addr  <= bus.dm_addr;
            r_mem_wdata <= bus.dm_wdata;
        end else if (w_done || w_abort) begin
            r_mem_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_err      <= 1'b0;
        end else begin
            r_if_ready <= (r_state == ST_SERVE_IF) && (w_done || w_abort);
            r_dm_ready <= (r_state == ST_SERVE_DM) && (w_done || w_abort);
            if (r_state == ST_SERVE_IF) begin
                if (w_done) r_if_rdata <= bus.mem_rdata;
                else if (w_abort) r_if_rdata <= '0;
            end
            if (r_state == ST_SERVE_DM) begin
                if (w_done) r_dm_rdata <= bus.mem_rdata;
                else if (w_abort) r_dm_rdata <= '0;
            end
            if (w_abort) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_grant_if) begin
            r_starve_cnt <= '0;
        end else if (w_grant_dm && bus.if_req && (r_starve_cnt != STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_ready  = r_if_ready;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_ready  = r_dm_ready;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.err       = r_err;
    assign bus.if_stall  = bus.if_req && !r_if_ready;
    assign bus.dm_stall  = bus.dm_req && !r_dm_ready;
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed plus randomized bench for mips_mem_arbiter with a transaction-level
// reference model of arbitration, starvation and timeout.
module tb_mips_mem_arbiter;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 255;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_starve = 0;
    bit   m_err = 1'b0;

    mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mips_mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (STARVE_LIMIT),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        bus.if_req  = 1'b0;
        bus.dm_req  = 1'b0;
        bus.mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_all();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_starve = 0;
        m_err = 1'b0;
    endtask

    // One arbitration round starting from IDLE at a negedge; the winner gets its
    // ack after `delay` ackless SERVE cycles. The loser keeps its request held.
    task automatic txn(input bit rq_if, input bit rq_dm, input bit we,
                       input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] wd, input logic [31:0] rd, input int delay);
        bit win_dm;
        logic [31:0] ea;
        win_dm = rq_dm && (!rq_if || (m_starve < STARVE_LIMIT));
        ea = win_dm ? da : ia;
        bus.if_req   = rq_if;
        bus.if_addr  = ia;
        bus.dm_req   = rq_dm;
        bus.dm_we    = we;
        bus.dm_addr  = da;
        bus.dm_wdata = wd;
        #1;
        chk1("if_stall_req", bus.if_stall, rq_if);
        chk1("dm_stall_req", bus.dm_stall, rq_dm);
        chk1("mem_req_idle", bus.mem_req, 1'b0);
        @(negedge clk);
        for (int k = 0; k <= delay; k++) begin
            chk1("mem_req_serve", bus.mem_req, 1'b1);
            chk("mem_addr", bus.mem_addr, ea);
            chk1("mem_we", bus.mem_we, win_dm && we);
            if (win_dm && we) chk("mem_wdata", bus.mem_wdata, wd);
            chk1("if_stall_serve", bus.if_stall, rq_if);
            chk1("dm_stall_serve", bus.dm_stall, rq_dm);
            chk1("if_ready_serve", bus.if_ready, 1'b0);
            chk1("dm_ready_serve", bus.dm_ready, 1'b0);
            if (k == delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rd;
            end
            @(negedge clk);
        end
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom();
        chk1("if_ready_resp", bus.if_ready, !win_dm);
        chk1("dm_ready_resp", bus.dm_ready, win_dm);
        if (win_dm) chk("dm_rdata", bus.dm_rdata, rd);
        else        chk("if_rdata", bus.if_rdata, rd);
        chk1("mem_req_resp", bus.mem_req, 1'b0);
        chk1("if_stall_resp", bus.if_stall, rq_if && win_dm);
        chk1("dm_stall_resp", bus.dm_stall, rq_dm && !win_dm);
        chk1("err_txn", bus.err, m_err);
        if (win_dm) begin
            bus.dm_req = 1'b0;
            if (rq_if && (m_starve < STARVE_LIMIT)) m_starve++;
        end else begin
            bus.if_req = 1'b0;
            m_starve = 0;
        end
        @(negedge clk);
        chk1("if_ready_after", bus.if_ready, 1'b0);
        chk1("dm_ready_after", bus.dm_ready, 1'b0);
    endtask

    initial begin
        int n;
        bus.if_req = 1'b0;  bus.if_addr = '0;
        bus.dm_req = 1'b0;  bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        do_reset();
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk1("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk1("rst_if_ready", bus.if_ready, 1'b0);
        chk1("rst_dm_ready", bus.dm_ready, 1'b0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_dm_rdata", bus.dm_rdata, 32'h0);
        chk1("rst_err", bus.err, 1'b0);

        // single fetch at minimum latency, then a delayed DM write
        txn(1'b1, 1'b0, 1'b0, 32'h0040_0000, 32'h0, 32'h0, 32'h2008_0005, 0);
        txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h1000_0004, 32'hDEAD_BEEF, $urandom(), 4);

        // both requesting continuously: DM x4, IF, DM x4, IF
        for (int i = 0; i < 10; i++) begin
            txn(1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                $urandom(), $urandom(), int'($urandom_range(0, 2)));
        end
        idle_all();
        @(negedge clk);

        // stray ack in IDLE
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk1("stray_mem_req", bus.mem_req, 1'b0);
        chk1("stray_if_ready", bus.if_ready, 1'b0);
        chk1("stray_dm_ready", bus.dm_ready, 1'b0);
        @(negedge clk);
        chk1("stray_if_ready2", bus.if_ready, 1'b0);
        chk1("stray_dm_ready2", bus.dm_ready, 1'b0);

        for (int i = 0; i < 30; i++) begin
            bit ri;
            bit rdm;
            ri  = 1'($urandom_range(0, 1));
            rdm = 1'($urandom_range(0, 1));
            if (!ri && !rdm) rdm = 1'b1;
            txn(ri, rdm, 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                $urandom(), $urandom(), int'($urandom_range(0, 5)));
        end
        idle_all();
        @(negedge clk);

        // reset in the middle of a DM read
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = $urandom();
        @(negedge clk);
        chk1("mid_mem_req", bus.mem_req, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk1("mid_rst_mem_req", bus.mem_req, 1'b0);
        chk("mid_rst_mem_addr", bus.mem_addr, 32'h0);
        chk1("mid_rst_dm_ready", bus.dm_ready, 1'b0);
        chk("mid_rst_dm_rdata", bus.dm_rdata, 32'h0);
        chk("mid_rst_if_rdata", bus.if_rdata, 32'h0);
        chk1("mid_rst_err", bus.err, 1'b0);
        reset = 1'b0;
        m_starve = 0;
        m_err = 1'b0;
        bus.dm_req = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk1("late_ack_ready", bus.dm_ready, 1'b0);
        chk1("late_ack_mem_req", bus.mem_req, 1'b0);
        @(negedge clk);
        chk1("late_ack_ready2", bus.dm_ready, 1'b0);

        txn(1'b0, 1'b1, 1'b0, 32'h0, $urandom(), 32'h0, 32'hCAFE_F00D, 1);

        // timeout: never ack a DM read
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = $urandom();
        @(negedge clk);
        n = 0;
        while ((bus.mem_req === 1'b1) && (n < 400)) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_serve_cycles", n, TIMEOUT);
        chk1("tmo_mem_req", bus.mem_req, 1'b0);
        chk1("tmo_dm_ready", bus.dm_ready, 1'b1);
        chk("tmo_dm_rdata", bus.dm_rdata, 32'h0);
        chk1("tmo_err", bus.err, 1'b1);
        m_err = 1'b1;
        bus.dm_req = 1'b0;
        @(negedge clk);
        chk1("tmo_dm_ready_after", bus.dm_ready, 1'b0);

        txn(1'b1, 1'b0, 1'b0, $urandom(), 32'h0, 32'h0, $urandom(), 2);
        chk1("err_sticky", bus.err, 1'b1);

        do_reset();
        chk1("err_cleared", bus.err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
